// File: rtl/fp_adder_pipe.sv
// fp_adder_pipe: three-stage parametrised IEEE-754 adder/subtractor with
// valid/ready streaming, five rounding modes, specials and exception flags.
module fp_adder_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   fp_a,
    input  logic [EXP_W+MAN_W:0]   fp_b,
    input  logic                   sub,
    input  logic [2:0]             r_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   fp_result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact,
    output logic                   invalid
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int AW = MAN_W + 3;
    localparam int NW = MAN_W + 4;
    localparam int EW = EXP_W + 1;
    localparam int RW = MAN_W + 2;
    localparam int LZ_W = $clog2(NW + 1);
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EXP_W-1:0] EMX1 = {{(EXP_W-1){1'b1}}, 1'b0};

    logic en;
    assign en = !out_valid | out_ready;
    assign in_ready = en;

    logic sa, sb, swap, a_nan, b_nan, a_inf, b_inf, inf_clash, far, st, nan, zs;
    logic [EXP_W-1:0] ea, eb, el, es, dif;
    logic [MAN_W:0] ml, ms;
    logic [2*AW-1:0] sh;
    logic [AW-1:0] al;
    logic [2:0] rm;
    logic [W-1:0] spec_v;

    always_comb begin
        sa = fp_a[W-1];
        sb = fp_b[W-1] ^ sub;
        ea = fp_a[W-2:MAN_W];
        eb = fp_b[W-2:MAN_W];
        a_nan = &ea & |fp_a[MAN_W-1:0];
        b_nan = &eb & |fp_b[MAN_W-1:0];
        a_inf = &ea & ~|fp_a[MAN_W-1:0];
        b_inf = &eb & ~|fp_b[MAN_W-1:0];
        inf_clash = a_inf & b_inf & (sa ^ sb);
        nan = a_nan | b_nan | inf_clash;
        spec_v = nan ? {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}} : {a_inf ? sa : sb, EMAX, {MAN_W{1'b0}}};
        swap = fp_b[W-2:0] > fp_a[W-2:0];
        ml = swap ? {|eb, fp_b[MAN_W-1:0]} : {|ea, fp_a[MAN_W-1:0]};
        ms = swap ? {|ea, fp_a[MAN_W-1:0]} : {|eb, fp_b[MAN_W-1:0]};
        // subnormals share the effective exponent 1 with the smallest normals
        el = swap ? (eb | EXP_W'(eb == '0)) : (ea | EXP_W'(ea == '0));
        es = swap ? (ea | EXP_W'(ea == '0)) : (eb | EXP_W'(eb == '0));
        dif = el - es;
        sh = {ms, 2'b00, {AW{1'b0}}} >> dif;
        far = 32'(dif) >= AW;
        al = far ? '0 : sh[2*AW-1:AW];
        st = far ? |ms : |sh[AW-1:0];
        rm = r_mode > 3'd4 ? 3'd0 : r_mode;
        zs = (sa ^ sb) ? (rm == 3'd2) : sa;
    end

    logic v1, s1_sign, s1_sub, s1_st, s1_zs, s1_spec, s1_inv;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W:0] s1_ml;
    logic [AW-1:0] s1_al;
    logic [2:0] s1_rm;
    logic [W-1:0] s1_spec_v;

    logic [NW:0] sum;
    logic [LZ_W-1:0] lz;
    logic [31:0] lim, shl;
    logic [NW-1:0] nm;
    logic [EW-1:0] ne;

    always_comb begin
        sum = s1_sub ? {1'b0, s1_ml, 3'b000} - {1'b0, s1_al, s1_st} : {1'b0, s1_ml, 3'b000} + {1'b0, s1_al, s1_st};
        lz = LZ_W'(NW);
        for (int i = 0; i < NW; i++) if (sum[i]) lz = LZ_W'(NW - 1 - i);
        // never normalise below exponent 1; what remains is a subnormal
        lim = 32'(s1_exp) - 32'd1;
        shl = (32'(lz) < lim) ? 32'(lz) : lim;
        nm = sum[NW] ? {sum[NW:2], |sum[1:0]} : sum[NW-1:0] << shl;
        ne = sum[NW] ? EW'(s1_exp) + EW'(1) : EW'(s1_exp) - EW'(shl);
    end

    logic v2, s2_sign, s2_zs, s2_spec, s2_inv;
    logic [EW-1:0] s2_exp;
    logic [NW-1:0] s2_man;
    logic [2:0] s2_rm;
    logic [W-1:0] s2_spec_v;

    logic lsb, g, r, s, grs, inc, hid, ovf, to_inf, zero;
    logic [RW-1:0] rnd;
    logic [EW-1:0] fe;
    logic [W-1:0] res;

    always_comb begin
        lsb = s2_man[3];
        g = s2_man[2];
        r = s2_man[1];
        s = s2_man[0];
        grs = g | r | s;
        inc = s2_rm == 3'd1 ? 1'b0 :
              s2_rm == 3'd2 ? s2_sign & grs :
              s2_rm == 3'd3 ? !s2_sign & grs :
              s2_rm == 3'd4 ? g : g & (r | s | lsb);
        rnd = {1'b0, s2_man[NW-1:3]} + RW'(inc);
        hid = rnd[MAN_W+1] | rnd[MAN_W];
        fe = s2_exp + EW'(rnd[MAN_W+1]);
        ovf = hid & (fe >= EW'(EMAX));
        to_inf = s2_rm == 3'd0 | s2_rm == 3'd4 | (s2_rm == 3'd3 & !s2_sign) | (s2_rm == 3'd2 & s2_sign);
        zero = !hid & ~|rnd[MAN_W-1:0];
        res = ovf ? (to_inf ? {s2_sign, EMAX, {MAN_W{1'b0}}} : {s2_sign, EMX1, {MAN_W{1'b1}}}) :
              {zero ? s2_zs : s2_sign, hid ? fe[EXP_W-1:0] : {EXP_W{1'b0}}, rnd[MAN_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
            fp_result <= '0;
            {overflow, underflow, inexact, invalid} <= 4'b0000;
        end else if (en) begin
            v1 <= in_valid;
            s1_sign <= swap ? sb : sa;
            s1_sub <= sa ^ sb;
            s1_exp <= el;
            s1_ml <= ml;
            s1_al <= al;
            s1_st <= st;
            s1_rm <= rm;
            s1_zs <= zs;
            s1_spec <= nan | a_inf | b_inf;
            s1_spec_v <= spec_v;
            s1_inv <= (a_nan & !fp_a[MAN_W-1]) | (b_nan & !fp_b[MAN_W-1]) | inf_clash;
            v2 <= v1;
            s2_sign <= s1_sign;
            s2_exp <= ne;
            s2_man <= nm;
            s2_rm <= s1_rm;
            s2_zs <= s1_zs;
            s2_spec <= s1_spec;
            s2_spec_v <= s1_spec_v;
            s2_inv <= s1_inv;
            out_valid <= v2;
            fp_result <= s2_spec ? s2_spec_v : res;
            {overflow, underflow, inexact, invalid} <= s2_spec ? {3'b000, s2_inv} : {ovf, !hid & grs, grs | ovf, 1'b0};
        end
    end
endmodule

// File: tb/tb_fp_adder_pipe.sv
// tb_fp_adder_pipe: scoreboard bench for fp_adder_pipe in single precision
// plus a half-precision instance for the parameter run.
module tb_fp_adder_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [31:0] fp_a = '0;
    logic [31:0] fp_b = '0;
    logic sub = 1'b0;
    logic [2:0] r_mode = 3'd0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [31:0] fp_result;
    logic overflow, underflow, inexact, invalid;

    logic h_valid = 1'b0;
    logic h_ready, h_out_valid, h_ov, h_un, h_ix, h_iv;
    logic [15:0] h_a = '0;
    logic [15:0] h_b = '0;
    logic [15:0] h_res;

    always #5 clk = ~clk;

    fp_adder_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fp_a(fp_a), .fp_b(fp_b), .sub(sub), .r_mode(r_mode),
        .out_valid(out_valid), .out_ready(out_ready), .fp_result(fp_result),
        .overflow(overflow), .underflow(underflow), .inexact(inexact), .invalid(invalid)
    );

    fp_adder_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_valid), .in_ready(h_ready),
        .fp_a(h_a), .fp_b(h_b), .sub(1'b0), .r_mode(3'd0),
        .out_valid(h_out_valid), .out_ready(1'b1), .fp_result(h_res),
        .overflow(h_ov), .underflow(h_un), .inexact(h_ix), .invalid(h_iv)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic s;
        logic [2:0] rm;
        logic [35:0] e;
    } vec_t;

    vec_t vq[$];
    logic [35:0] exp_q[$];
    int pop_cyc[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [35:0] e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [2:0] rm,
                       input logic [31:0] res, input logic [3:0] fl);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.rm = rm; v.e = {res, fl};
        vq.push_back(v);
    endtask

    task automatic present(input int k);
        fp_a = vq[k].a; fp_b = vq[k].b; sub = vq[k].s; r_mode = vq[k].rm; in_valid = 1'b1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious", out_valid, 0);
            else begin
                e = exp_q.pop_front();
                chk("result", {fp_result, overflow, underflow, inexact, invalid}, e);
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic drive(input int lo, input int hi, output int n);
        int i;
        i = lo;
        n = 0;
        while (i <= hi && n < 500) begin
            present(i);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(vq[i].e);
                i++;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("drive_done", i, hi + 1);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic one_beat(input int k, input string tag);
        present(k);
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1);
        exp_q.push_back(vq[k].e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk({tag, "_lat"}, out_valid, c == 3);
            if (c < 3) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic half_beat(input logic [15:0] a, input logic [15:0] b, input logic [19:0] want, input string tag);
        h_a = a; h_b = b; h_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, h_ready, 1);
        @(posedge clk); #1;
        h_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(tag, {h_out_valid, h_res, h_ov, h_un, h_ix, h_iv}, {1'b1, want});
        @(posedge clk); #1;
    endtask

    initial begin
        int n, acc;
        int bp[4];
        logic done;
        logic [31:0] snap;
        bp = '{0, 3, 5, 13};
        add(32'h3F800000, 32'h3F800000, 0, 3'd0, 32'h40000000, 4'b0000);
        add(32'h000A0000, 32'h000A0000, 0, 3'd1, 32'h00140000, 4'b0000);
        add(32'h3F800000, 32'h33800000, 0, 3'd0, 32'h3F800000, 4'b0010);
        add(32'h3F800000, 32'h33800000, 0, 3'd3, 32'h3F800001, 4'b0010);
        add(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 3'd0, 32'h7F800000, 4'b1010);
        add(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 3'd1, 32'h7F7FFFFF, 4'b1010);
        add(32'h3F800000, 32'h3F800000, 1, 3'd0, 32'h00000000, 4'b0000);
        add(32'h3F800000, 32'h3F800000, 1, 3'd2, 32'h80000000, 4'b0000);
        add(32'h7F800000, 32'hFF800000, 0, 3'd0, 32'h7FC00000, 4'b0001);
        add(32'h7F800001, 32'h00000000, 0, 3'd0, 32'h7FC00000, 4'b0001);
        add(32'h3F800000, 32'h33800000, 0, 3'd4, 32'h3F800001, 4'b0010);
        add(32'h3F800000, 32'h33800000, 1, 3'd0, 32'h3F7FFFFF, 4'b0000);
        add(32'h00800000, 32'h00000001, 1, 3'd1, 32'h007FFFFF, 4'b0000);
        add(32'hC0000000, 32'h3F800000, 0, 3'd0, 32'hBF800000, 4'b0000);
        add(32'h3F800000, 32'h00000001, 0, 3'd3, 32'h3F800001, 4'b0010);
        add(32'hFF800000, 32'h3F800000, 0, 3'd0, 32'hFF800000, 4'b0000);
        add(32'h7FC00000, 32'h3F800000, 0, 3'd0, 32'h7FC00000, 4'b0000);
        add(32'h3F800000, 32'h33800000, 0, 3'd7, 32'h3F800000, 4'b0010);
        add(32'h3F800000, 32'hBF800000, 0, 3'd2, 32'h80000000, 4'b0000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {out_valid, fp_result, overflow, underflow, inexact, invalid}, 0);
        chk("rst_rdy", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        one_beat(0, "first");

        drive(0, 3, n);
        chk("b2b_in", n, 4);
        drain("b2b_drain");
        chk("b2b_out", pop_cyc[$] - pop_cyc[$-3], 3);

        drive(4, 18, n);
        drain("all_drain");

        done = 1'b0;
        fork
            begin
                drive(0, 18, n);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("rand_drain");

        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            present(bp[acc]);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(vq[bp[acc]].e);
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_acc", acc, 3);
        chk("bp_rdy", in_ready, 0);
        chk("bp_head", {out_valid, fp_result}, {1'b1, 32'h40000000});
        snap = fp_result;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_hold", fp_result, snap);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("bp_drain");

        present(0);
        @(negedge clk);
        chk("mid_rdy0", in_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rdy1", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_quiet", out_valid, 0);
            @(posedge clk); #1;
        end
        one_beat(13, "post_rst");

        half_beat(16'h3C00, 16'h3C00, {16'h4000, 4'b0000}, "half_one");
        half_beat(16'h7BFF, 16'h7BFF, {16'h7C00, 4'b1010}, "half_ovf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_adder_pipe.md
# fp_adder_pipe

Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor with a valid/ready stream interface. It generalises the single-precision combinational adder datapath to any exponent/mantissa width and adds a true subtract mode. It adds full guard/round/sticky rounding across five modes, IEEE special-value handling and IEEE exception flags. It sits in the ALU next to the other FP units, fed by the operand issue stage and drained by the writeback arbiter.

## Interface
- EXP_W, 8, exponent field width (≥ 4)
- MAN_W, 23, stored fraction width (≥ 4); word width W = 1+EXP_W+MAN_W
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- fp_a, fp_b  in  W  operands
- sub  in  1  1 = compute fp_a − fp_b (flip sign of fp_b before add)
- r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- fp_result  out  W  rounded result
- overflow, underflow, inexact, invalid  out  1 each  IEEE exception flags, qualified by out_valid

## Operation
- Stage S1 (unpack/align):
  - Split fields. Subnormal: hidden bit 0, effective exponent 1. Zero/inf/NaN are detected.
  - Swap so the larger magnitude is the left operand.
  - Right-shift the smaller operand by the exponent difference into a MAN_W+4 field: hidden, fraction, G, R; shifted-out bits OR into S.
  - Differences ≥ MAN_W+3 leave only S set (S = 1 iff smaller operand ≠ 0).
- Stage S2 (add/normalise):
  - Effective op = sign_a XOR sign_b XOR sub. Add magnitudes, or subtract smaller from larger; result never negative; result sign = larger operand's sign.
  - Carry-out: shift right 1, exponent+1, shifted bit ORs into sticky.
  - Otherwise: left-shift by leading-zero count, clamped so the exponent does not go below 1. The result becomes subnormal at exponent 1 with hidden bit 0.
- Stage S3 (round/pack):
  - RNE: increment if G & (R|S|lsb).
  - RTZ: never increment.
  - RDN: increment if sign & (G|R|S).
  - RUP: increment if !sign & (G|R|S).
  - RMM: increment if G.
  - Rounding carry out of the fraction: exponent+1, fraction 0. A subnormal rounding up to hidden bit 1 becomes the minimum normal.
  - Pack {sign, exp, frac}.
- Exact zero result:
  - Signs differ: +0, except RDN gives −0.
  - Both operands −0 (after sub flip): −0.
- Specials (override datapath, flags as listed):
  - Any NaN input: canonical qNaN {0, all-ones, 1, zeros}. invalid=1 iff any input is a signalling NaN (fraction MSB 0).
  - +inf plus −inf (effective): qNaN, invalid=1.
  - inf plus finite: that inf, no flags.
- Overflow (rounded exponent ≥ all-ones): overflow=1, inexact=1.
  - Result is inf for RNE, RMM, RUP(+) and RDN(−).
  - Otherwise the result is max finite {sign, all-ones−1, all-ones}.
- inexact = G|R|S at rounding, or overflow.
- underflow = result is subnormal or zero after rounding, and inexact.

## Timing
- Three register stages, one beat per cycle throughput.
- Beat accepted in cycle t (in_valid & in_ready) → out_valid in cycle t+3 if no stall.
- Global advance enable en = !out_valid | out_ready. in_ready = en; every stage register and valid bit updates only when en = 1.
- Stall: while out_valid & !out_ready, fp_result and flags hold stable. in_ready=0; up to 3 beats held in flight, none dropped or duplicated.
- Bubbles: in_valid=0 while en propagates a 0 valid bit; no spurious out_valid.
- in_ready has no combinational path from in_valid. Its only combinational input is out_ready.
- Reset:
  - All valid bits clear the cycle after rst is sampled high.
  - Output values during reset: out_valid=0, fp_result=0, all flags 0.
  - in_ready = 1 during and after reset.
  - Reset mid-operation discards in-flight beats; the first post-reset beat behaves normally.
- No state outside the pipeline; all behaviour is order-preserving.

## Test plan
- 3F800000 + 3F800000, RNE, out_ready=1 → 40000000 at t+3, flags 0. Back-to-back 4 beats emerge on 4 consecutive cycles in order.
- 000A0000 + 000A0000, RTZ → 00140000, underflow=0, inexact=0. 3F800000 + 33800000: RNE → 3F800000, inexact=1; RUP → 3F800001.
- 7F7FFFFF + 7F7FFFFF: RNE → 7F800000, overflow=1, inexact=1; RTZ → 7F7FFFFF, overflow=1.
- 3F800000 − 3F800000 (sub=1): RNE → 00000000; RDN → 80000000. 7F800000 + FF800000 → 7FC00000, invalid=1. 7F800001 + 0 → 7FC00000, invalid=1.
- Backpressure: out_ready=0, in_valid=1 for 6 cycles. Exactly 3 beats accepted, in_ready=0 afterwards, fp_result stable. Release out_ready and all beats drain in order with correct values.
- Assert rst in the cycle after 2 beats were accepted → out_valid=0, no result for those beats. The next beat after rst deassert returns at t+3.
- Parameter run EXP_W=5, MAN_W=10: 3C00 + 3C00 RNE → 4000; 7BFF + 7BFF RNE → 7C00, overflow=1.
